// File: rtl/rvfpm_issue_ctrl.sv
`default_nettype none
// ============================================================================
// rvfpm_issue_ctrl : in-order FP issue queue with RAW interlock, kill-by-id
//                    and a fixed-latency execution pipe tracker.
// Revision: 1.0
// ============================================================================
module rvfpm_issue_ctrl #(
    parameter int X_ID_WIDTH      = 4,
    parameter int PIPELINE_STAGES = 4,
    parameter int QUEUE_DEPTH     = 4,
    parameter int NUM_F_REGS      = 32,
    localparam int RW             = $clog2(NUM_F_REGS)
) (
    input  logic                                  ck,
    input  logic                                  rst,
    input  logic                                  enable,
    input  logic                                  in_valid,
    output logic                                  fpu_ready,
    input  logic [X_ID_WIDTH-1:0]                 in_id,
    input  logic [RW-1:0]                         in_rd,
    input  logic [3*RW-1:0]                       in_rs,
    input  logic [2:0]                            in_rs_used,
    input  logic                                  in_we,
    input  logic                                  kill_valid,
    input  logic [X_ID_WIDTH-1:0]                 kill_id,
    output logic                                  issue_valid,
    output logic [X_ID_WIDTH-1:0]                 issue_id,
    output logic [PIPELINE_STAGES-1:0]            pipe_valid,
    output logic [PIPELINE_STAGES*X_ID_WIDTH-1:0] pipe_ids,
    output logic                                  retire_valid,
    output logic [X_ID_WIDTH-1:0]                 retire_id,
    output logic [RW-1:0]                         retire_rd,
    output logic                                  retire_we
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int LS = PIPELINE_STAGES - 1;
    localparam logic [PW-1:0] C_LAST_PTR = PW'(QUEUE_DEPTH - 1);
    localparam logic [CW-1:0] C_DEPTH    = CW'(QUEUE_DEPTH);

    // Instruction FIFO storage
    logic [X_ID_WIDTH-1:0] fid_q    [QUEUE_DEPTH];
    logic [RW-1:0]         frd_q    [QUEUE_DEPTH];
    logic [3*RW-1:0]       frs_q    [QUEUE_DEPTH];
    logic [2:0]            fused_q  [QUEUE_DEPTH];
    logic                  fwe_q    [QUEUE_DEPTH];
    logic                  fkill_q  [QUEUE_DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;

    // Execution pipe tracking
    logic [PIPELINE_STAGES-1:0] pv_q,  pv_d;
    logic [PIPELINE_STAGES-1:0] pwe_q, pwe_d;
    logic [X_ID_WIDTH-1:0]      pid_q [PIPELINE_STAGES];
    logic [X_ID_WIDTH-1:0]      pid_d [PIPELINE_STAGES];
    logic [RW-1:0]              prd_q [PIPELINE_STAGES];
    logic [RW-1:0]              prd_d [PIPELINE_STAGES];

    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_issue;
    logic                  w_discard;
    logic                  w_hazard;
    logic                  w_kill_head;
    logic                  w_kill_tail;
    logic [X_ID_WIDTH-1:0] w_head_id;
    logic [RW-1:0]         w_head_rd;
    logic [3*RW-1:0]       w_head_rs;
    logic [2:0]            w_head_used;
    logic                  w_head_we;
    logic                  w_head_killed;

    assign w_empty       = (count_q == '0);
    // Held low while in reset so nothing upstream sees a ready queue.
    assign fpu_ready     = rst & (count_q != C_DEPTH);
    assign w_push        = in_valid & fpu_ready;

    assign w_head_id     = fid_q[rd_ptr_q];
    assign w_head_rd     = frd_q[rd_ptr_q];
    assign w_head_rs     = frs_q[rd_ptr_q];
    assign w_head_used   = fused_q[rd_ptr_q];
    assign w_head_we     = fwe_q[rd_ptr_q];
    assign w_head_killed = fkill_q[rd_ptr_q];

    always_comb begin
        w_hazard = 1'b0;
        for (int s = 0; s < PIPELINE_STAGES; s++) begin
            for (int i = 0; i < 3; i++) begin
                if (w_head_used[i] && pv_q[s] && pwe_q[s] &&
                    (prd_q[s] == w_head_rs[i*RW +: RW])) begin
                    w_hazard = 1'b1;
                end
            end
        end
    end

    assign w_kill_head = kill_valid & (w_head_id == kill_id);
    assign w_issue     = enable & ~w_empty & ~w_head_killed & ~w_hazard & ~w_kill_head;
    assign w_discard   = enable & ~w_empty & w_head_killed;
    assign w_pop       = w_issue | w_discard;

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            for (int e = 0; e < QUEUE_DEPTH; e++) begin
                fid_q[e]   <= '0;
                frd_q[e]   <= '0;
                frs_q[e]   <= '0;
                fused_q[e] <= '0;
                fwe_q[e]   <= 1'b0;
                fkill_q[e] <= 1'b0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int e = 0; e < QUEUE_DEPTH; e++) begin
                if (kill_valid && (fid_q[e] == kill_id)) begin
                    fkill_q[e] <= 1'b1;
                end
            end
            // A same-cycle push lands after the kill scan, so it stays live.
            if (w_push) begin
                fid_q[wr_ptr_q]   <= in_id;
                frd_q[wr_ptr_q]   <= in_rd;
                frs_q[wr_ptr_q]   <= in_rs;
                fused_q[wr_ptr_q] <= in_rs_used;
                fwe_q[wr_ptr_q]   <= in_we;
                fkill_q[wr_ptr_q] <= 1'b0;
                wr_ptr_q <= (wr_ptr_q == C_LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= (rd_ptr_q == C_LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
            end
            if (w_push && !w_pop) begin
                count_q <= count_q + CW'(1);
            end else if (w_pop && !w_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    always_comb begin
        pv_d  = pv_q;
        pwe_d = pwe_q;
        pid_d = pid_q;
        prd_d = prd_q;
        if (enable) begin
            pv_d[0]  = w_issue;
            pwe_d[0] = w_issue & w_head_we;
            pid_d[0] = w_issue ? w_head_id : '0;
            prd_d[0] = w_issue ? w_head_rd : '0;
            for (int s = 1; s < PIPELINE_STAGES; s++) begin
                pv_d[s]  = pv_q[s-1];
                pwe_d[s] = pwe_q[s-1];
                pid_d[s] = pid_q[s-1];
                prd_d[s] = prd_q[s-1];
            end
        end
        // Kill applies to post-shift contents so an entry moving stages is caught too.
        if (kill_valid) begin
            for (int s = 0; s < PIPELINE_STAGES; s++) begin
                if (pid_d[s] == kill_id) begin
                    pv_d[s] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            pv_q  <= '0;
            pwe_q <= '0;
            for (int s = 0; s < PIPELINE_STAGES; s++) begin
                pid_q[s] <= '0;
                prd_q[s] <= '0;
            end
        end else begin
            pv_q  <= pv_d;
            pwe_q <= pwe_d;
            pid_q <= pid_d;
            prd_q <= prd_d;
        end
    end

    generate
        for (genvar g = 0; g < PIPELINE_STAGES; g++) begin : g_pack_ids
            assign pipe_ids[g*X_ID_WIDTH +: X_ID_WIDTH] = pid_q[g];
        end
    endgenerate

    assign w_kill_tail  = kill_valid & (pid_q[LS] == kill_id);
    assign pipe_valid   = pv_q;
    assign issue_valid  = w_issue;
    assign issue_id     = w_issue ? w_head_id : '0;
    assign retire_valid = enable & pv_q[LS] & ~w_kill_tail;
    assign retire_id    = retire_valid ? pid_q[LS] : '0;
    assign retire_rd    = retire_valid ? prd_q[LS] : '0;
    assign retire_we    = retire_valid & pwe_q[LS];

endmodule
`default_nettype wire

// File: tb/tb_rvfpm_issue_ctrl.sv
`default_nettype none
// ============================================================================
// tb_rvfpm_issue_ctrl : scoreboard bench for rvfpm_issue_ctrl (S=4, depth 4).
// Revision: 1.0
// ============================================================================
module tb_rvfpm_issue_ctrl;

    logic        ck;
    logic        rst;
    logic        enable;
    logic        in_valid;
    logic        fpu_ready;
    logic [3:0]  in_id;
    logic [4:0]  in_rd;
    logic [14:0] in_rs;
    logic [2:0]  in_rs_used;
    logic        in_we;
    logic        kill_valid;
    logic [3:0]  kill_id;
    logic        issue_valid;
    logic [3:0]  issue_id;
    logic [3:0]  pipe_valid;
    logic [15:0] pipe_ids;
    logic        retire_valid;
    logic [3:0]  retire_id;
    logic [4:0]  retire_rd;
    logic        retire_we;

    rvfpm_issue_ctrl #(
        .X_ID_WIDTH      (4),
        .PIPELINE_STAGES (4),
        .QUEUE_DEPTH     (4),
        .NUM_F_REGS      (32)
    ) dut (
        .ck           (ck),
        .rst          (rst),
        .enable       (enable),
        .in_valid     (in_valid),
        .fpu_ready    (fpu_ready),
        .in_id        (in_id),
        .in_rd        (in_rd),
        .in_rs        (in_rs),
        .in_rs_used   (in_rs_used),
        .in_we        (in_we),
        .kill_valid   (kill_valid),
        .kill_id      (kill_id),
        .issue_valid  (issue_valid),
        .issue_id     (issue_id),
        .pipe_valid   (pipe_valid),
        .pipe_ids     (pipe_ids),
        .retire_valid (retire_valid),
        .retire_id    (retire_id),
        .retire_rd    (retire_rd),
        .retire_we    (retire_we)
    );

    typedef struct {
        logic [3:0] id;
        int         cyc;
    } iss_t;

    typedef struct {
        logic [3:0] id;
        logic [4:0] rd;
        logic       we;
        int         lat;
    } ret_t;

    iss_t exp_iss[$];
    ret_t exp_ret[$];
    int   issued_at [16];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    initial ck = 1'b0;
    always #5 ck = ~ck;

    always @(posedge ck) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    // Expectations are queued at the accept point, ahead of any DUT reaction.
    task automatic push(input logic [3:0] id, input logic [4:0] rd, input logic [14:0] rs,
                        input logic [2:0] used, input logic we,
                        input int iss_off, input int lat, output int pcyc);
        int   waited;
        iss_t ei;
        ret_t er;
        waited     = 0;
        in_valid   = 1'b1;
        in_id      = id;
        in_rd      = rd;
        in_rs      = rs;
        in_rs_used = used;
        in_we      = we;
        while (fpu_ready !== 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        if (waited >= 40) chk("push_timeout", waited, 0);
        pcyc = cyc;
        if (iss_off >= 0) begin
            ei.id  = id;
            ei.cyc = pcyc + iss_off;
            exp_iss.push_back(ei);
        end
        if (lat >= 0) begin
            er.id  = id;
            er.rd  = rd;
            er.we  = we;
            er.lat = lat;
            exp_ret.push_back(er);
        end
        tick();
        in_valid = 1'b0;
    endtask

    always @(negedge ck) begin
        iss_t ei;
        ret_t er;
        if (issue_valid === 1'b1) begin
            if (exp_iss.size() == 0) begin
                chk("unexpected_issue_id", int'(issue_id), -1);
            end else begin
                ei = exp_iss.pop_front();
                chk("issue_id", int'(issue_id), int'(ei.id));
                chk("issue_cycle", cyc, ei.cyc);
            end
            issued_at[issue_id] = cyc;
        end
        if (retire_valid === 1'b1) begin
            if (exp_ret.size() == 0) begin
                chk("unexpected_retire_id", int'(retire_id), -1);
            end else begin
                er = exp_ret.pop_front();
                chk("retire_id", int'(retire_id), int'(er.id));
                chk("retire_rd", int'(retire_rd), int'(er.rd));
                chk("retire_we", int'(retire_we), int'(er.we));
                chk("retire_latency", cyc - issued_at[retire_id], er.lat);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, p3, p8;
        for (int i = 0; i < 16; i++) issued_at[i] = 0;
        rst = 1'b0; enable = 1'b1; in_valid = 1'b0; in_id = '0; in_rd = '0;
        in_rs = '0; in_rs_used = '0; in_we = 1'b0; kill_valid = 1'b0; kill_id = '0;
        repeat (2) tick();
        chk("rst_pipe_valid", int'(pipe_valid), 0);
        chk("rst_pipe_ids", int'(pipe_ids), 0);
        chk("rst_issue_valid", int'(issue_valid), 0);
        chk("rst_retire_valid", int'(retire_valid), 0);
        chk("rst_fpu_ready", int'(fpu_ready), 0);
        #3 rst = 1'b1;
        tick();
        chk("post_rst_fpu_ready", int'(fpu_ready), 1);

        // Independent instruction: issue next cycle, retire 4 later
        push(4'd1, 5'd3, 15'd0, 3'b000, 1'b1, 1, 4, p);
        repeat (8) tick();

        // RAW dependence on f5: second issue 5 cycles after the first
        push(4'd1, 5'd5, 15'd0, 3'b000, 1'b1, 1, 4, p);
        push(4'd2, 5'd6, 15'd5, 3'b001, 1'b0, 5, 4, p);
        tick();
        chk("raw_pipe_valid_mid", int'(pipe_valid), 4'b0010);
        chk("raw_pipe_id_s1", int'(pipe_ids[7:4]), 1);
        repeat (3) tick();
        chk("raw_pipe_valid_gap", int'(pipe_valid), 0);
        chk("raw_issue_now", int'(issue_valid), 1);
        repeat (8) tick();

        // Full queue behind a stalled head
        push(4'd3, 5'd7,  15'd0, 3'b000, 1'b1, 1, 4, p3);
        push(4'd4, 5'd8,  15'd7, 3'b001, 1'b1, 5, 4, p);
        push(4'd5, 5'd9,  15'd0, 3'b000, 1'b1, 5, 4, p);
        push(4'd6, 5'd10, 15'd0, 3'b000, 1'b1, 5, 4, p);
        push(4'd7, 5'd11, 15'd0, 3'b000, 1'b1, 5, 4, p);
        chk("full_fpu_ready", int'(fpu_ready), 0);
        push(4'd8, 5'd12, 15'd0, 3'b000, 1'b1, 3, 4, p8);
        chk("full_accept_delay", p8 - p3, 7);
        repeat (10) tick();

        // Kill a queued entry: id 2 discarded, one bubble between 1 and 3
        enable = 1'b0;
        push(4'd1, 5'd1, 15'd0, 3'b000, 1'b1, 4, 4, p);
        push(4'd2, 5'd2, 15'd0, 3'b000, 1'b1, -1, -1, p);
        push(4'd3, 5'd3, 15'd0, 3'b000, 1'b1, 4, 4, p);
        kill_valid = 1'b1; kill_id = 4'd2;
        tick();
        kill_valid = 1'b0; enable = 1'b1;
        tick();
        chk("kill_discard_cycle", int'(issue_valid), 0);
        repeat (10) tick();

        // Kill while in stage 2
        push(4'd9, 5'd1, 15'd0, 3'b000, 1'b1, 1, -1, p);
        repeat (3) tick();
        chk("kill_s2_before", int'(pipe_valid), 4'b0100);
        kill_valid = 1'b1; kill_id = 4'd9;
        tick();
        kill_valid = 1'b0;
        chk("kill_s2_after", int'(pipe_valid), 0);
        repeat (4) tick();

        // Kill while retiring suppresses retire combinationally
        push(4'd10, 5'd2, 15'd0, 3'b000, 1'b1, 1, -1, p);
        repeat (4) tick();
        chk("kill_s3_retire_before", int'(retire_valid), 1);
        kill_valid = 1'b1; kill_id = 4'd10;
        #1;
        chk("kill_s3_retire_masked", int'(retire_valid), 0);
        tick();
        kill_valid = 1'b0;
        chk("kill_s3_pipe_after", int'(pipe_valid), 0);
        repeat (3) tick();

        // Push and kill of the same id in one cycle: pushed entry survives
        kill_valid = 1'b1; kill_id = 4'd11;
        push(4'd11, 5'd4, 15'd0, 3'b000, 1'b1, 1, 4, p);
        kill_valid = 1'b0;
        repeat (8) tick();

        // Freeze for 3 cycles while the entry sits in the last stage
        push(4'd12, 5'd2, 15'd0, 3'b000, 1'b1, 1, 7, p);
        repeat (4) tick();
        chk("frz_pipe_valid_pre", int'(pipe_valid), 4'b1000);
        enable = 1'b0;
        tick();
        chk("frz_pipe_valid", int'(pipe_valid), 4'b1000);
        chk("frz_pipe_id_s3", int'(pipe_ids[15:12]), 12);
        chk("frz_retire_valid", int'(retire_valid), 0);
        repeat (2) tick();
        enable = 1'b1;
        repeat (6) tick();

        // Asynchronous reset mid-flight
        push(4'd13, 5'd3, 15'd0, 3'b000, 1'b1, 1, -1, p);
        repeat (2) tick();
        chk("arst_pipe_valid_pre", int'(pipe_valid), 4'b0010);
        #2 rst = 1'b0;
        #1;
        chk("arst_pipe_valid", int'(pipe_valid), 0);
        chk("arst_pipe_ids", int'(pipe_ids), 0);
        chk("arst_issue_valid", int'(issue_valid), 0);
        chk("arst_retire_valid", int'(retire_valid), 0);
        chk("arst_fpu_ready", int'(fpu_ready), 0);
        #2 rst = 1'b1;
        tick();
        chk("arst_release_ready", int'(fpu_ready), 1);
        push(4'd14, 5'd6, 15'd0, 3'b000, 1'b1, 1, 4, p);
        repeat (8) tick();

        chk("pending_issues", exp_iss.size(), 0);
        chk("pending_retires", exp_ret.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
